// File: rtl/ups_pkg.sv
// Shared register map, CTRL bit positions and state encoding for the UPS pulse generator.
package ups_pkg;

  localparam int unsigned CTRL_IDX = 0;
  localparam int unsigned DLY_IDX  = 1;
  localparam int unsigned WID_IDX  = 2;
  localparam int unsigned PER_IDX  = 3;
  localparam int unsigned CNT_IDX  = 4;

  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_STOP  = 1;

  typedef enum logic [1:0] {
    PG_IDLE,
    PG_DELAY,
    PG_HIGH,
    PG_LOW
  } pg_state_t;

endpackage

// File: rtl/ups_dcnt.sv
// Loadable down-counter that saturates at zero; zero_c flags the terminal value.
module ups_dcnt #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero_c
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/ups_pulse_gen.sv
// Programmable pulse train (delay, width, period, count) armed and aborted by register-file writes.
module ups_pulse_gen
  import ups_pkg::*;
#(
  parameter int unsigned DW = 8,
  parameter int unsigned CW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   reg_data [DW-1:0],
  input  logic [DW-1:0] reg_dv,
  output logic          pulse_out,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [CW-1:0] pulse_cnt
);

  pg_state_t state, state_nxt;

  logic [CW-1:0] in_dly, in_wid, in_per, in_cnt;
  logic [CW-1:0] sh_wid, sh_per, sh_cnt;
  logic          start_c, stop_c, cfg_ok_c, cont_c;
  logic          ph_load, ph_en, ph_zero_c;
  logic [CW-1:0] ph_val;
  logic          rem_load, rem_en, rem_zero_c;
  logic [CW-1:0] rem_val;
  logic          done_nxt, err_nxt, cnt_clr, enter_high;
  logic          unused_bits_c;

  assign start_c  = reg_dv[CTRL_IDX] && reg_data[CTRL_IDX][CTRL_START]
                    && !reg_data[CTRL_IDX][CTRL_STOP];
  assign stop_c   = reg_dv[CTRL_IDX] && reg_data[CTRL_IDX][CTRL_STOP];
  assign in_dly   = reg_data[DLY_IDX][CW-1:0];
  assign in_wid   = reg_data[WID_IDX][CW-1:0];
  assign in_per   = reg_data[PER_IDX][CW-1:0];
  assign in_cnt   = reg_data[CNT_IDX][CW-1:0];
  assign cfg_ok_c = (in_wid != '0) && (in_per > in_wid);
  assign cont_c   = (sh_cnt == '0);

  // Register contents outside the used fields are deliberately ignored.
  always_comb begin
    unused_bits_c = ^reg_dv;
    for (int i = 0; i < int'(DW); i++) begin
      unused_bits_c = unused_bits_c ^ (^reg_data[i]);
    end
  end

  ups_dcnt #(.W(CW)) u_phase (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ph_load),
    .load_val (ph_val),
    .en       (ph_en),
    .zero_c   (ph_zero_c)
  );

  ups_dcnt #(.W(CW)) u_remain (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (rem_load),
    .load_val (rem_val),
    .en       (rem_en),
    .zero_c   (rem_zero_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= PG_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Phase counters hold (length - 1); a phase ends on the cycle its counter reads zero.
  always_comb begin
    state_nxt = state;
    ph_load   = 1'b0;
    ph_val    = '0;
    ph_en     = 1'b0;
    rem_load  = 1'b0;
    rem_val   = in_cnt - CW'(1);
    rem_en    = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = err;
    cnt_clr   = 1'b0;
    unique case (state)
      PG_IDLE: begin
        if (start_c) begin
          err_nxt = !cfg_ok_c;
          if (cfg_ok_c) begin
            cnt_clr  = 1'b1;
            rem_load = 1'b1;
            ph_load  = 1'b1;
            if (in_dly != '0) begin
              state_nxt = PG_DELAY;
              ph_val    = in_dly - CW'(1);
            end else begin
              state_nxt = PG_HIGH;
              ph_val    = in_wid - CW'(1);
            end
          end
        end
      end
      PG_DELAY: begin
        ph_en = 1'b1;
        if (ph_zero_c) begin
          state_nxt = PG_HIGH;
          ph_load   = 1'b1;
          ph_val    = sh_wid - CW'(1);
        end
      end
      PG_HIGH: begin
        ph_en = 1'b1;
        if (ph_zero_c) begin
          rem_en = !cont_c;
          if (!cont_c && rem_zero_c) begin
            state_nxt = PG_IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = PG_LOW;
            ph_load   = 1'b1;
            ph_val    = sh_per - sh_wid - CW'(1);
          end
        end
      end
      PG_LOW: begin
        ph_en = 1'b1;
        if (ph_zero_c) begin
          state_nxt = PG_HIGH;
          ph_load   = 1'b1;
          ph_val    = sh_wid - CW'(1);
        end
      end
      default: state_nxt = PG_IDLE;
    endcase
    // Abort wins over everything, including a completion in the same cycle.
    if (stop_c && (state != PG_IDLE)) begin
      state_nxt = PG_IDLE;
      done_nxt  = 1'b0;
      ph_load   = 1'b0;
      rem_en    = 1'b0;
    end
  end

  assign enter_high = (state_nxt == PG_HIGH) && (state != PG_HIGH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pulse_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      pulse_cnt <= '0;
      sh_wid    <= '0;
      sh_per    <= '0;
      sh_cnt    <= '0;
    end else begin
      pulse_out <= (state_nxt == PG_HIGH);
      busy      <= (state_nxt != PG_IDLE);
      done      <= done_nxt;
      err       <= err_nxt;
      pulse_cnt <= (cnt_clr ? '0 : pulse_cnt) + CW'(enter_high);
      if ((state == PG_IDLE) && start_c) begin
        sh_wid <= in_wid;
        sh_per <= in_per;
        sh_cnt <= in_cnt;
      end
    end
  end

endmodule

// File: tb/tb_ups_pulse_gen.sv
// Self-checking bench for ups_pulse_gen: directed table, corner sequences, randomized run vs schedule model.
module tb_ups_pulse_gen;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   reg_data [DW-1:0];
  logic [DW-1:0] reg_dv;
  logic          pulse_out, busy, done, err;
  logic [CW-1:0] pulse_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ups_pulse_gen #(.DW(DW), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .reg_data  (reg_data),
    .reg_dv    (reg_dv),
    .pulse_out (pulse_out),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .pulse_cnt (pulse_cnt)
  );

  // Reference model: the train is a closed-form schedule in k = cycles since acceptance.
  bit m_active, m_done, m_err;
  int m_k, m_cnt, md, mw, mp, mc;

  function automatic bit m_high(input int k);
    int m;
    m = k - 1 - md;
    return (m >= 0) && ((m % mp) < mw);
  endfunction

  function automatic int m_pc(input int k);
    int m;
    m = k - 1 - md;
    return (m < 0) ? 0 : (m / mp + 1);
  endfunction

  function automatic int m_last();
    return md + (mc - 1) * mp + mw;
  endfunction

  task automatic model_edge();
    bit start, stop, nd;
    int d, w, p, c;
    nd    = 1'b0;
    stop  = reg_dv[0] && reg_data[0][1];
    start = reg_dv[0] && reg_data[0][0] && !reg_data[0][1];
    d = int'(reg_data[1]); w = int'(reg_data[2]);
    p = int'(reg_data[3]); c = int'(reg_data[4]);
    if (!rst_n) begin
      m_active = 0; m_done = 0; m_err = 0; m_cnt = 0;
      return;
    end
    if (m_active) begin
      if (stop) begin
        m_cnt = m_pc(m_k); m_active = 0;
      end else if (mc != 0 && m_k == m_last()) begin
        m_cnt = mc; m_active = 0; nd = 1'b1;
      end else begin
        m_k++;
      end
    end else if (start) begin
      if (w == 0 || p <= w) begin
        m_err = 1;
      end else begin
        m_err = 0; m_active = 1; m_k = 1;
        md = d; mw = w; mp = p; mc = c;
      end
    end
    m_done = nd;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("m_pulse", 32'(pulse_out), 32'(m_active && m_high(m_k)));
    check("m_busy",  32'(busy),      32'(m_active));
    check("m_done",  32'(done),      32'(m_done));
    check("m_err",   32'(err),       32'(m_err));
    check("m_cnt",   pulse_cnt,      32'(m_active ? m_pc(m_k) : m_cnt));
  endtask

  task automatic cyc(input logic [DW-1:0] dv, input logic [31:0] ctrl);
    reg_dv      = dv;
    reg_data[0] = ctrl;
    model_edge();
    @(posedge clk);
    #1;
    check_model();
    reg_dv = '0;
  endtask

  task automatic cfg(input int d, input int w, input int p, input int c);
    reg_data[1] = 32'(d); reg_data[2] = 32'(w);
    reg_data[3] = 32'(p); reg_data[4] = 32'(c);
  endtask

  typedef struct {
    logic        dv;
    logic [31:0] ctrl;
    logic        pulse;
    logic        busy;
    logic        done;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl [12];

  task automatic run_table(input string tag);
    cfg(2, 3, 5, 2);
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].dv ? 8'h01 : 8'h00, tbl[i].ctrl);
      check({tag, "_pulse"}, 32'(pulse_out), 32'(tbl[i].pulse));
      check({tag, "_busy"},  32'(busy),      32'(tbl[i].busy));
      check({tag, "_done"},  32'(done),      32'(tbl[i].done));
      check({tag, "_cnt"},   pulse_cnt,      tbl[i].cnt);
    end
  endtask

  initial begin
    int rises, dones;
    bit prev, dseen;

    // Outputs expected in cycle T+1+i after inputs applied in cycle T+i.
    tbl[0]  = '{1'b1, 32'h1, 1'b0, 1'b1, 1'b0, 32'd0};
    tbl[1]  = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'd0};
    tbl[2]  = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'd1};
    tbl[3]  = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'd1};
    tbl[4]  = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'd1};
    tbl[5]  = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'd1};
    tbl[6]  = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'd1};
    tbl[7]  = '{1'b1, 32'h1, 1'b1, 1'b1, 1'b0, 32'd2};
    tbl[8]  = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'd2};
    tbl[9]  = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'd2};
    tbl[10] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'd2};
    tbl[11] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'd2};

    for (int i = 0; i < int'(DW); i++) reg_data[i] = 32'hFFFF_FFFF;
    reg_dv = '0;
    rst_n  = 1'b0;
    cyc('0, 32'h0);
    cyc('0, 32'h0);
    check("rst_pulse", 32'(pulse_out), 32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_done",  32'(done),      32'd0);
    check("rst_err",   32'(err),       32'd0);
    check("rst_cnt",   pulse_cnt,      32'd0);
    rst_n = 1'b1;
    cyc('0, 32'h0);

    // Finite train with delay; START mid-train (row 7) must be ignored.
    run_table("s1");

    // Continuous train, stop after ten pulses.
    cfg(0, 1, 2, 0);
    cyc(8'h01, 32'h1);
    check("s2_first_high", 32'(pulse_out), 32'd1);
    dseen = 1'b0;
    for (int i = 0; i < 40 && pulse_cnt != 10; i++) begin
      cyc('0, 32'h0);
      dseen |= done;
    end
    check("s2_reach10", pulse_cnt, 32'd10);
    cyc(8'h01, 32'h2);
    dseen |= done;
    check("s2_stop_pulse", 32'(pulse_out), 32'd0);
    check("s2_stop_busy",  32'(busy),      32'd0);
    check("s2_stop_cnt",   pulse_cnt,      32'd10);
    check("s2_no_done",    32'(dseen),     32'd0);

    // Invalid config (PERIOD == WIDTH), then recovery.
    cfg(0, 4, 4, 1);
    cyc(8'h01, 32'h1);
    check("s3_err",  32'(err),  32'd1);
    check("s3_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) cyc('0, 32'h0);
    check("s3_low", 32'(pulse_out), 32'd0);
    cfg(0, 2, 4, 1);
    cyc(8'h01, 32'h1);
    check("s3_err_clr", 32'(err),  32'd0);
    check("s3_run",     32'(busy), 32'd1);
    for (int i = 0; i < 6; i++) cyc('0, 32'h0);

    // Mid-train WIDTH write plus START: schedule unchanged.
    cfg(1, 2, 4, 3);
    rises = 0; dones = 0; prev = 1'b0;
    cyc(8'h01, 32'h1);
    for (int i = 0; i < 20; i++) begin
      if (i == 4) begin
        reg_data[2] = 32'd9;
        cyc(8'h05, 32'h1);
      end else begin
        cyc('0, 32'h0);
      end
      if (pulse_out && !prev) rises++;
      prev = pulse_out;
      dones += int'(done);
    end
    check("s4_rises", 32'(rises), 32'd3);
    check("s4_dones", 32'(dones), 32'd1);

    // START+STOP together: idle no-op, busy abort.
    cfg(0, 0, 3, 1);
    cyc(8'h01, 32'h1);
    cyc(8'h01, 32'h3);
    check("s5_idle_err",  32'(err),  32'd1);
    check("s5_idle_busy", 32'(busy), 32'd0);
    cfg(1, 2, 5, 0);
    cyc(8'h01, 32'h1);
    for (int i = 0; i < 4; i++) cyc('0, 32'h0);
    cyc(8'h01, 32'h3);
    check("s5_abort_busy",  32'(busy),      32'd0);
    check("s5_abort_pulse", 32'(pulse_out), 32'd0);
    check("s5_abort_done",  32'(done),      32'd0);

    // Reset during HIGH, then a clean replay of the first scenario.
    cfg(2, 3, 5, 2);
    cyc(8'h01, 32'h1);
    for (int i = 0; i < 2; i++) cyc('0, 32'h0);
    check("s6_high", 32'(pulse_out), 32'd1);
    rst_n = 1'b0;
    cyc('0, 32'h0);
    check("s6_rst_pulse", 32'(pulse_out), 32'd0);
    check("s6_rst_busy",  32'(busy),      32'd0);
    check("s6_rst_cnt",   pulse_cnt,      32'd0);
    rst_n = 1'b1;
    cyc('0, 32'h0);
    run_table("s6");

    // Randomized traffic against the schedule model.
    for (int i = 0; i < 3000; i++) begin
      logic [DW-1:0] dv;
      logic [31:0]   ctrl;
      if ($urandom_range(0, 7) == 0) begin
        cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
      end
      reg_data[5] = $urandom;
      reg_data[7] = $urandom;
      dv   = DW'($urandom) & 8'hFE;
      ctrl = 32'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) dv[0] = 1'b1;
      rst_n = ($urandom_range(0, 299) != 0);
      cyc(dv, ctrl);
    end
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
